ebus_dev_resp: RTL and testbench
================================

Name: ebus_dev_resp

Overview:
- EBUS device-side responder: the far end of the EBUS data path that the EDP slices drive onto ebus_dNN_e_h.
- Decodes controller-select and function for one device code, then handshakes DEMAND/XFER with the EBUS master.
- CONO/DATAO: captures the 36-bit EBUS word into the device. CONI/DATAI: returns a device word onto the EBUS.
- Sits between the EBUS backplane model and a simple local device register set.

Parameters:
- DEV_CS, 7'o0, controller-select code this instance answers to.
- RDY_TIMEOUT, 16, maximum cycles DATAI waits for local_rdy_h before abandoning the transfer.

Ports:
- clk_h  in  1  system clock, all state on rising edge.
- reset_h  in  1  asynchronous, active-high reset.
- ebus_cs_h  in  7  controller select from master.
- ebus_func_h  in  3  function: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI, others ignored.
- ebus_demand_h  in  1  master request, held until XFER is seen.
- ebus_d_in_h  in  36  EBUS data as seen by device (bit 0 = MSB).
- ebus_d_out_h  out  36  data driven by device.
- ebus_d_oe_h  out  1  device drives EBUS data.
- ebus_xfer_h  out  1  device transfer acknowledge.
- local_coni_h  in  36  device status word.
- local_datai_h  in  36  device data word.
- local_rdy_h  in  1  local_datai_h valid.
- local_wdata_h  out  36  captured CONO/DATAO word.
- local_cono_h  out  1  one-cycle CONO strobe.
- local_datao_h  out  1  one-cycle DATAO strobe.
- local_datai_ack_h  out  1  one-cycle pulse when the DATAI word is handed to EBUS.

Behaviour:
- Reset: every output 0; FSM in IDLE. Reset mid-transfer aborts immediately and drops oe/xfer asynchronously.
- Selection: demand, cs==DEV_CS, and func in 0..3 must all be sampled true on 2 consecutive cycles (deglitch). The 2nd sample moves IDLE->DECODE. cs/func are latched at that point and are ignored afterwards.
- DECODE (1 cycle):
  - CONO/DATAO: local_wdata_h <= ebus_d_in_h; pulse local_cono_h or local_datao_h this cycle; go to XFER.
  - CONI: ebus_d_out_h <= local_coni_h, oe=1; go to XFER.
  - DATAI: go to WAIT_RDY with timeout counter = RDY_TIMEOUT.
- WAIT_RDY:
  - local_rdy_h=1: ebus_d_out_h <= local_datai_h, oe=1, pulse local_datai_ack_h; go to XFER.
  - Counter decrements each cycle without rdy. At 0, go to RELEASE without XFER; the master times out.
  - rdy and counter expiry on the same cycle: rdy wins.
- XFER: ebus_xfer_h=1 (registered; first asserted the cycle after entry). oe and data stay stable. Holds until demand is sampled 0, then go to RELEASE.
- RELEASE (1 cycle): xfer=0. oe stays 1 this cycle (data hold after XFER falls), then oe=0 and ebus_d_out_h=0. Returns to IDLE only once demand=0; a new request needs demand low for at least 1 cycle.
- Latency, demand rise to xfer rise: 4 cycles for CONO/CONI/DATAO with stable inputs (2 deglitch, DECODE, XFER register); DATAI adds the WAIT_RDY time.
- Demand drops during DECODE or WAIT_RDY: abandon to RELEASE. Any CONO/DATAO strobe already issued is not retracted.
- Unselected cs or func 4..7: no outputs change.
- ebus_d_out_h is 0 whenever oe=0.

Test Plan:
- CONO with DEV_CS=7'o14, cs=7'o14, func=0, data=36'o123456701234, demand held -> local_cono_h single pulse, local_wdata_h=36'o123456701234, xfer rises 4 cycles after demand; demand drop -> xfer falls next cycle, idle after RELEASE.
- CONI with local_coni_h=36'o777000000001 -> oe=1, ebus_d_out_h=36'o777000000001 before xfer rises; data held through the RELEASE cycle, then 0.
- DATAI with local_rdy_h raised 5 cycles after DECODE, local_datai_h=36'o400000000000 -> single datai_ack pulse, data on bus, xfer rises next cycle. Repeat with rdy never asserted, RDY_TIMEOUT=16 -> no xfer, oe never 1, FSM back in IDLE after demand drops.
- Wrong cs (7'o15), func=5, and a 1-cycle demand glitch -> no strobes, oe=0, xfer=0.
- reset_h pulsed while in XFER for CONI -> xfer and oe drop immediately. After release, a following DATAO completes normally with local_datao_h pulse.
- Back-to-back DATAO/DATAO with demand low for 1 cycle between -> two strobes, two xfer pulses, second wdata correct.

Source files
------------

// File: rtl/ebus_dev_resp.sv
// EBUS device-side responder: deglitched select decode, DEMAND/XFER handshake,
// and the CONO/DATAO capture and CONI/DATAI return paths for one device code.
module ebus_dev_resp #(
    parameter logic [6:0] DEV_CS      = 7'o0,
    parameter int         RDY_TIMEOUT = 16
) (
    input  logic        clk_h,
    input  logic        reset_h,
    input  logic [6:0]  ebus_cs_h,
    input  logic [2:0]  ebus_func_h,
    input  logic        ebus_demand_h,
    input  logic [0:35] ebus_d_in_h,
    output logic [0:35] ebus_d_out_h,
    output logic        ebus_d_oe_h,
    output logic        ebus_xfer_h,
    input  logic [0:35] local_coni_h,
    input  logic [0:35] local_datai_h,
    input  logic        local_rdy_h,
    output logic [0:35] local_wdata_h,
    output logic        local_cono_h,
    output logic        local_datao_h,
    output logic        local_datai_ack_h
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_XFER   = 3'd3;
    localparam logic [2:0] S_REL    = 3'd4;

    localparam logic [1:0] F_CONO  = 2'd0;
    localparam logic [1:0] F_CONI  = 2'd1;
    localparam logic [1:0] F_DATAO = 2'd2;
    localparam logic [1:0] F_DATAI = 2'd3;

    localparam int CNT_W = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT + 1) : 1;

    logic             sel;
    logic             sel_p0;
    logic [2:0]       state;
    logic [1:0]       func_q;
    logic [CNT_W-1:0] cnt;
    logic             rel_ok;

    assign sel = ebus_demand_h && (ebus_cs_h == DEV_CS) && !ebus_func_h[2];

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state             <= S_IDLE;
            sel_p0            <= 1'b0;
            func_q            <= F_CONO;
            cnt               <= '0;
            rel_ok            <= 1'b0;
            ebus_d_out_h      <= '0;
            ebus_d_oe_h       <= 1'b0;
            ebus_xfer_h       <= 1'b0;
            local_wdata_h     <= '0;
            local_cono_h      <= 1'b0;
            local_datao_h     <= 1'b0;
            local_datai_ack_h <= 1'b0;
        end else begin
            sel_p0            <= 1'b0;
            local_cono_h      <= 1'b0;
            local_datao_h     <= 1'b0;
            local_datai_ack_h <= 1'b0;

            case (state)
                // Select must hold for two consecutive samples before decoding
                S_IDLE: begin
                    sel_p0 <= sel;
                    if (sel && sel_p0) begin
                        state  <= S_DECODE;
                        func_q <= ebus_func_h[1:0];
                    end
                end

                S_DECODE: begin
                    rel_ok <= 1'b1;
                    case (func_q)
                        F_CONO, F_DATAO: begin
                            local_wdata_h <= ebus_d_in_h;
                            local_cono_h  <= (func_q == F_CONO);
                            local_datao_h <= (func_q == F_DATAO);
                            state         <= ebus_demand_h ? S_XFER : S_REL;
                        end
                        F_CONI: begin
                            if (ebus_demand_h) begin
                                ebus_d_out_h <= local_coni_h;
                                ebus_d_oe_h  <= 1'b1;
                                state        <= S_XFER;
                            end else begin
                                state <= S_REL;
                            end
                        end
                        F_DATAI: begin
                            cnt   <= CNT_W'(RDY_TIMEOUT);
                            state <= ebus_demand_h ? S_WAIT : S_REL;
                        end
                        default: state <= S_REL;
                    endcase
                end

                // rdy is checked ahead of counter expiry so it wins a tie
                S_WAIT: begin
                    if (!ebus_demand_h) begin
                        state <= S_REL;
                    end else if (local_rdy_h) begin
                        ebus_d_out_h      <= local_datai_h;
                        ebus_d_oe_h       <= 1'b1;
                        local_datai_ack_h <= 1'b1;
                        state             <= S_XFER;
                    end else if (cnt == '0) begin
                        rel_ok <= 1'b0;
                        state  <= S_REL;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_XFER: begin
                    if (ebus_demand_h) begin
                        ebus_xfer_h <= 1'b1;
                    end else begin
                        ebus_xfer_h <= 1'b0;
                        state       <= S_REL;
                    end
                end

                // rel_ok means demand was already seen low; a timed-out
                // transfer waits here until the master gives up
                S_REL: begin
                    ebus_xfer_h  <= 1'b0;
                    ebus_d_oe_h  <= 1'b0;
                    ebus_d_out_h <= '0;
                    if (!ebus_demand_h || rel_ok) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_dev_resp.sv
// Directed bench for ebus_dev_resp: one task per scenario with inline checks.
module tb_ebus_dev_resp;

    logic        clk_h = 1'b0;
    logic        reset_h;
    logic [6:0]  ebus_cs_h;
    logic [2:0]  ebus_func_h;
    logic        ebus_demand_h;
    logic [0:35] ebus_d_in_h;
    logic [0:35] ebus_d_out_h;
    logic        ebus_d_oe_h;
    logic        ebus_xfer_h;
    logic [0:35] local_coni_h;
    logic [0:35] local_datai_h;
    logic        local_rdy_h;
    logic [0:35] local_wdata_h;
    logic        local_cono_h;
    logic        local_datao_h;
    logic        local_datai_ack_h;

    int checks = 0;
    int errors = 0;

    ebus_dev_resp #(.DEV_CS(7'o14), .RDY_TIMEOUT(16)) dut (
        .clk_h(clk_h),
        .reset_h(reset_h),
        .ebus_cs_h(ebus_cs_h),
        .ebus_func_h(ebus_func_h),
        .ebus_demand_h(ebus_demand_h),
        .ebus_d_in_h(ebus_d_in_h),
        .ebus_d_out_h(ebus_d_out_h),
        .ebus_d_oe_h(ebus_d_oe_h),
        .ebus_xfer_h(ebus_xfer_h),
        .local_coni_h(local_coni_h),
        .local_datai_h(local_datai_h),
        .local_rdy_h(local_rdy_h),
        .local_wdata_h(local_wdata_h),
        .local_cono_h(local_cono_h),
        .local_datao_h(local_datao_h),
        .local_datai_ack_h(local_datai_ack_h)
    );

    always #5 clk_h = ~clk_h;

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic drive_req(input logic [6:0] c, input logic [2:0] f, input logic [0:35] d);
        ebus_cs_h     = c;
        ebus_func_h   = f;
        ebus_d_in_h   = d;
        ebus_demand_h = 1'b1;
    endtask

    task automatic idle_bus(input int n);
        ebus_demand_h = 1'b0;
        ebus_cs_h     = 7'o0;
        ebus_func_h   = 3'd0;
        ebus_d_in_h   = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset_h       = 1'b1;
        ebus_demand_h = 1'b0;
        ebus_cs_h     = 7'o14;
        ebus_func_h   = 3'd0;
        ebus_d_in_h   = 36'o777777777777;
        local_coni_h  = '0;
        local_datai_h = '0;
        local_rdy_h   = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ebus_d_oe_h, ebus_xfer_h, local_cono_h, local_datao_h, local_datai_ack_h} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got oe=%0b xfer=%0b cono=%0b datao=%0b ack=%0b, want all 0",
                     ebus_d_oe_h, ebus_xfer_h, local_cono_h, local_datao_h, local_datai_ack_h);
        end
        checks++;
        if (ebus_d_out_h !== 36'o0 || local_wdata_h !== 36'o0) begin
            errors++;
            $display("FAIL reset_data: got d_out=%o wdata=%o, want 0", ebus_d_out_h, local_wdata_h);
        end
        @(negedge clk_h);
        reset_h = 1'b0;
        idle_bus(2);
    endtask

    task automatic test_cono();
        drive_req(7'o14, 3'd0, 36'o123456701234);
        tick();
        tick();
        checks++;
        if (local_cono_h !== 1'b0 || local_wdata_h !== 36'o0) begin
            errors++;
            $display("FAIL cono_early: got cono=%0b wdata=%o, want 0/0", local_cono_h, local_wdata_h);
        end
        tick();
        checks++;
        if (local_cono_h !== 1'b1 || local_datao_h !== 1'b0 || local_wdata_h !== 36'o123456701234) begin
            errors++;
            $display("FAIL cono_strobe: got cono=%0b datao=%0b wdata=%o, want 1/0/123456701234",
                     local_cono_h, local_datao_h, local_wdata_h);
        end
        checks++;
        if (ebus_xfer_h !== 1'b0) begin
            errors++;
            $display("FAIL cono_xfer_pre: got %0b want 0", ebus_xfer_h);
        end
        tick();
        checks++;
        if (ebus_xfer_h !== 1'b1 || local_cono_h !== 1'b0 || ebus_d_oe_h !== 1'b0) begin
            errors++;
            $display("FAIL cono_xfer_rise: got xfer=%0b cono=%0b oe=%0b, want 1/0/0",
                     ebus_xfer_h, local_cono_h, ebus_d_oe_h);
        end
        tick();
        checks++;
        if (ebus_xfer_h !== 1'b1) begin
            errors++;
            $display("FAIL cono_xfer_hold: got %0b want 1", ebus_xfer_h);
        end
        ebus_demand_h = 1'b0;
        tick();
        checks++;
        if (ebus_xfer_h !== 1'b0) begin
            errors++;
            $display("FAIL cono_xfer_fall: got %0b want 0", ebus_xfer_h);
        end
        idle_bus(2);
    endtask

    task automatic test_coni();
        local_coni_h = 36'o777000000001;
        drive_req(7'o14, 3'd1, 36'o0);
        repeat (3) tick();
        checks++;
        if (ebus_d_oe_h !== 1'b1 || ebus_d_out_h !== 36'o777000000001 || ebus_xfer_h !== 1'b0) begin
            errors++;
            $display("FAIL coni_data: got oe=%0b d_out=%o xfer=%0b, want 1/777000000001/0",
                     ebus_d_oe_h, ebus_d_out_h, ebus_xfer_h);
        end
        tick();
        checks++;
        if (ebus_xfer_h !== 1'b1) begin
            errors++;
            $display("FAIL coni_xfer: got %0b want 1", ebus_xfer_h);
        end
        ebus_demand_h = 1'b0;
        tick();
        checks++;
        if (ebus_xfer_h !== 1'b0 || ebus_d_oe_h !== 1'b1 || ebus_d_out_h !== 36'o777000000001) begin
            errors++;
            $display("FAIL coni_release_hold: got xfer=%0b oe=%0b d_out=%o, want 0/1/777000000001",
                     ebus_xfer_h, ebus_d_oe_h, ebus_d_out_h);
        end
        tick();
        checks++;
        if (ebus_d_oe_h !== 1'b0 || ebus_d_out_h !== 36'o0) begin
            errors++;
            $display("FAIL coni_release_drop: got oe=%0b d_out=%o, want 0/0", ebus_d_oe_h, ebus_d_out_h);
        end
        idle_bus(2);
    endtask

    task automatic test_datai();
        local_datai_h = 36'o400000000000;
        local_rdy_h   = 1'b0;
        drive_req(7'o14, 3'd3, 36'o0);
        repeat (7) tick();
        checks++;
        if (ebus_d_oe_h !== 1'b0 || local_datai_ack_h !== 1'b0 || ebus_xfer_h !== 1'b0) begin
            errors++;
            $display("FAIL datai_wait: got oe=%0b ack=%0b xfer=%0b, want 0/0/0",
                     ebus_d_oe_h, local_datai_ack_h, ebus_xfer_h);
        end
        local_rdy_h = 1'b1;
        tick();
        local_rdy_h = 1'b0;
        checks++;
        if (local_datai_ack_h !== 1'b1 || ebus_d_oe_h !== 1'b1 || ebus_d_out_h !== 36'o400000000000
            || ebus_xfer_h !== 1'b0) begin
            errors++;
            $display("FAIL datai_ack: got ack=%0b oe=%0b d_out=%o xfer=%0b, want 1/1/400000000000/0",
                     local_datai_ack_h, ebus_d_oe_h, ebus_d_out_h, ebus_xfer_h);
        end
        tick();
        checks++;
        if (local_datai_ack_h !== 1'b0 || ebus_xfer_h !== 1'b1 || ebus_d_out_h !== 36'o400000000000) begin
            errors++;
            $display("FAIL datai_xfer: got ack=%0b xfer=%0b d_out=%o, want 0/1/400000000000",
                     local_datai_ack_h, ebus_xfer_h, ebus_d_out_h);
        end
        ebus_demand_h = 1'b0;
        repeat (2) tick();
        checks++;
        if (ebus_xfer_h !== 1'b0 || ebus_d_oe_h !== 1'b0 || ebus_d_out_h !== 36'o0) begin
            errors++;
            $display("FAIL datai_release: got xfer=%0b oe=%0b d_out=%o, want 0/0/0",
                     ebus_xfer_h, ebus_d_oe_h, ebus_d_out_h);
        end
        idle_bus(2);
    endtask

    task automatic test_datai_timeout();
        int seen;
        seen = 0;
        local_rdy_h = 1'b0;
        drive_req(7'o14, 3'd3, 36'o0);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ebus_d_oe_h || ebus_xfer_h || local_datai_ack_h) seen++;
        end
        // Transfer is abandoned by now: a late rdy must be ignored
        local_rdy_h = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ebus_d_oe_h || ebus_xfer_h || local_datai_ack_h) seen++;
        end
        local_rdy_h = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL datai_timeout: got %0d active cycles, want 0", seen);
        end
        idle_bus(2);
        drive_req(7'o14, 3'd0, 36'o000000000077);
        repeat (3) tick();
        checks++;
        if (local_cono_h !== 1'b1 || local_wdata_h !== 36'o000000000077) begin
            errors++;
            $display("FAIL timeout_then_idle: got cono=%0b wdata=%o, want 1/77", local_cono_h, local_wdata_h);
        end
        idle_bus(3);
    endtask

    task automatic test_unselected();
        int seen;
        seen = 0;
        drive_req(7'o15, 3'd0, 36'o111111111111);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (local_cono_h || local_datao_h || ebus_d_oe_h || ebus_xfer_h) seen++;
        end
        idle_bus(2);
        drive_req(7'o14, 3'd5, 36'o222222222222);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (local_cono_h || local_datao_h || ebus_d_oe_h || ebus_xfer_h) seen++;
        end
        idle_bus(2);
        drive_req(7'o14, 3'd2, 36'o333333333333);
        tick();
        ebus_demand_h = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (local_cono_h || local_datao_h || ebus_d_oe_h || ebus_xfer_h) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL unselected_outputs: got %0d active cycles, want 0", seen);
        end
        checks++;
        if (local_wdata_h !== 36'o000000000077) begin
            errors++;
            $display("FAIL unselected_wdata: got %o want 77", local_wdata_h);
        end
        idle_bus(2);
    endtask

    task automatic test_reset_mid_xfer();
        local_coni_h = 36'o000000000123;
        drive_req(7'o14, 3'd1, 36'o0);
        repeat (4) tick();
        checks++;
        if (ebus_xfer_h !== 1'b1 || ebus_d_oe_h !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got xfer=%0b oe=%0b, want 1/1", ebus_xfer_h, ebus_d_oe_h);
        end
        #2;
        reset_h = 1'b1;
        #1;
        checks++;
        if (ebus_xfer_h !== 1'b0 || ebus_d_oe_h !== 1'b0 || ebus_d_out_h !== 36'o0) begin
            errors++;
            $display("FAIL rst_async_drop: got xfer=%0b oe=%0b d_out=%o, want 0/0/0",
                     ebus_xfer_h, ebus_d_oe_h, ebus_d_out_h);
        end
        ebus_demand_h = 1'b0;
        @(negedge clk_h);
        @(negedge clk_h);
        reset_h = 1'b0;
        idle_bus(2);
        drive_req(7'o14, 3'd2, 36'o555555555555);
        repeat (3) tick();
        checks++;
        if (local_datao_h !== 1'b1 || local_cono_h !== 1'b0 || local_wdata_h !== 36'o555555555555) begin
            errors++;
            $display("FAIL rst_then_datao: got datao=%0b cono=%0b wdata=%o, want 1/0/555555555555",
                     local_datao_h, local_cono_h, local_wdata_h);
        end
        tick();
        checks++;
        if (ebus_xfer_h !== 1'b1 || local_datao_h !== 1'b0) begin
            errors++;
            $display("FAIL rst_then_datao_xfer: got xfer=%0b datao=%0b, want 1/0", ebus_xfer_h, local_datao_h);
        end
        idle_bus(3);
    endtask

    task automatic test_back_to_back();
        int strobes;
        int xfer_rises;
        logic xfer_prev;
        strobes    = 0;
        xfer_rises = 0;
        xfer_prev  = 1'b0;
        drive_req(7'o14, 3'd2, 36'o010203040506);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (local_datao_h) strobes++;
            if (ebus_xfer_h && !xfer_prev) xfer_rises++;
            xfer_prev = ebus_xfer_h;
        end
        ebus_demand_h = 1'b0;
        tick();
        if (local_datao_h) strobes++;
        xfer_prev = ebus_xfer_h;
        checks++;
        if (ebus_xfer_h !== 1'b0 || local_wdata_h !== 36'o010203040506) begin
            errors++;
            $display("FAIL b2b_first: got xfer=%0b wdata=%o, want 0/010203040506", ebus_xfer_h, local_wdata_h);
        end
        drive_req(7'o14, 3'd2, 36'o765432107654);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (local_datao_h) strobes++;
            if (ebus_xfer_h && !xfer_prev) xfer_rises++;
            xfer_prev = ebus_xfer_h;
        end
        checks++;
        if (strobes !== 2 || xfer_rises !== 2) begin
            errors++;
            $display("FAIL b2b_counts: got strobes=%0d xfers=%0d, want 2/2", strobes, xfer_rises);
        end
        checks++;
        if (local_wdata_h !== 36'o765432107654 || ebus_xfer_h !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got wdata=%o xfer=%0b, want 765432107654/1", local_wdata_h, ebus_xfer_h);
        end
        idle_bus(3);
    endtask

    initial begin
        test_reset();
        test_cono();
        test_coni();
        test_datai();
        test_datai_timeout();
        test_unselected();
        test_reset_mid_xfer();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
